// File: rtl/alu_pkg.sv
// Shared ALU opcode constants, issue-controller state encoding and default operand width.
package alu_pkg;

  localparam int ALU_N = 8;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_watchdog.sv
// WAIT-state cycle counter for the ALU issue controller.
// Latency: expired is combinational in the LIMIT-th counted cycle.
// Backpressure: none; it only counts while inc is high.
module alu_watchdog #(
  parameter int LIMIT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] cnt;

  // cnt holds the number of WAIT cycles already completed, so the limit is hit
  // during the cycle in which cnt == LIMIT-1.
  assign expired = inc && (cnt == CW'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: one op at a time, cmd handshake in, registered ALU drive, result handshake out.
// Latency: accept->ISSUE 1 cycle, WAIT until alu_data_valid, RESP the cycle after; min 4 cycles accept-to-accept.
// Backpressure: cmd_ready low outside IDLE; RESP holds until rsp_ready. Optional WAIT timeout: ALU_TIMEOUT_EN.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int         N              = ALU_N,
  parameter logic [3:0] MAX_OP         = OP_DIV,
  parameter int         TIMEOUT_CYCLES = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [N-1:0]   cmd_a,
  input  logic [N-1:0]   cmd_b,
  input  logic [3:0]     cmd_op,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [2*N-1:0] rsp_result,
  output logic           rsp_err,
  output logic [N-1:0]   alu_a,
  output logic [N-1:0]   alu_b,
  output logic [3:0]     alu_op,
  output logic           alu_enable,
  input  logic [2*N-1:0] alu_result,
  input  logic           alu_data_valid,
  output logic           busy
);

  state_t         state_q, state_d;
  logic [N-1:0]   a_d, b_d;
  logic [3:0]     op_d;
  logic [2*N-1:0] res_d;
  logic           err_d;
  logic           timeout_hit;

`ifdef ALU_TIMEOUT_EN
  logic wd_expired;

  alu_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q == ISSUE),
    .inc     (state_q == WAIT),
    .expired (wd_expired)
  );

  assign timeout_hit = wd_expired;
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = alu_a;
    b_d     = alu_b;
    op_d    = alu_op;
    res_d   = rsp_result;
    err_d   = rsp_err;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          a_d  = cmd_a;
          b_d  = cmd_b;
          op_d = cmd_op;
          if (cmd_op > MAX_OP) begin
            state_d = RESP;
            res_d   = '0;
            err_d   = 1'b1;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      // data_valid seen in ISSUE belongs to a previous enable and is dropped.
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (alu_data_valid) begin
          state_d = RESP;
          res_d   = alu_result;
          err_d   = 1'b0;
        end else if (timeout_hit) begin
          state_d = RESP;
          res_d   = '0;
          err_d   = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Every output is a flop decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      alu_enable <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_ready  <= (state_d == IDLE);
      rsp_valid  <= (state_d == RESP);
      rsp_result <= res_d;
      rsp_err    <= err_d;
      alu_a      <= a_d;
      alu_b      <= b_d;
      alu_op     <= op_d;
      alu_enable <= (state_d == ISSUE) || (state_d == WAIT);
      busy       <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU and transaction-level timing model.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int TMO = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_a, cmd_b;
  logic [3:0]  cmd_op;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_err;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_op;
  logic        alu_enable;
  logic [15:0] alu_result;
  logic        alu_data_valid;
  logic        busy;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_enable(alu_enable),
    .alu_result(alu_result), .alu_data_valid(alu_data_valid),
    .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ALU model: data_valid in WAIT cycle alu_delay (enable cycle 1 is ISSUE); -1 means never.
  int alu_delay    = -1;
  bit alu_force_dv = 1'b0;
  int en_cycles    = 0;

  function automatic logic [15:0] alu_fn(logic [7:0] a, logic [7:0] b, logic [3:0] op);
    logic [15:0] r;
    case (op)
      OP_ADD:  r = {8'h00, a} + {8'h00, b};
      OP_SUB:  r = {8'h00, a} - {8'h00, b};
      OP_MUL:  r = 16'(a) * 16'(b);
      OP_DIV:  r = (b == 8'h00) ? 16'h0000 : 16'(a / b);
      default: r = 16'hDEAD;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (alu_enable) en_cycles = en_cycles + 1;
    else            en_cycles = 0;
    alu_data_valid = alu_force_dv || (alu_enable && alu_delay >= 0 && en_cycles == alu_delay + 1);
    alu_result     = alu_data_valid ? alu_fn(alu_a, alu_b, alu_op) : 16'($urandom);
  end

  // Observations from one transaction, sample index 1 = first negedge after the accepting edge.
  int          o_ready_ret, o_first_rsp, o_en_cnt, o_rsp_cnt;
  logic [15:0] o_res;
  logic        o_err;
  bit          o_held, o_stable, o_busy_ok;

  task automatic do_txn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                        input int delay, input int stall);
    int w = 0;
    while (cmd_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    alu_delay = delay;
    rsp_ready = (stall == 0);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
    @(negedge clk);
    o_ready_ret = -1; o_first_rsp = -1; o_en_cnt = 0; o_rsp_cnt = 0;
    o_res = 'x; o_err = 1'bx; o_held = 1; o_stable = 1; o_busy_ok = 1;
    for (int s = 1; s <= 200; s++) begin
      if (s > 1) @(negedge clk);
      // Commands offered while busy must be ignored.
      cmd_valid = 1'($urandom); cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_op = 4'($urandom);
      if (busy !== ~cmd_ready) o_busy_ok = 0;
      if (alu_enable === 1'b1) begin
        o_en_cnt++;
        if (alu_a !== a || alu_b !== b || alu_op !== op) o_stable = 0;
      end
      if (rsp_valid === 1'b1) begin
        o_rsp_cnt++;
        if (o_rsp_cnt == 1) begin
          o_first_rsp = s; o_res = rsp_result; o_err = rsp_err;
        end else if (rsp_result !== o_res || rsp_err !== o_err) begin
          o_held = 0;
        end
        rsp_ready = (o_rsp_cnt > stall);
      end
      if (cmd_ready === 1'b1) begin
        o_ready_ret = s;
        cmd_valid = 1'b0;
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_a = 8'h5A; cmd_b = 8'hA5; cmd_op = 4'h1; rsp_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_ready_busy got=%b%b exp=10", cmd_ready, busy); end
    n_checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_result !== 16'h0) begin n_fail++; $display("FAIL reset_rsp got=%b%b%h exp=000000", rsp_valid, rsp_err, rsp_result); end
    n_checks++; if (alu_enable !== 1'b0 || {alu_a, alu_b, alu_op} !== 20'h0) begin n_fail++; $display("FAIL reset_alu got=%b%h exp=000000", alu_enable, {alu_a, alu_b, alu_op}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add();
    do_txn(8'hDA, 8'h2B, OP_ADD, 1, 0);
    n_checks++; if (o_res !== 16'h0105 || o_err !== 1'b0) begin n_fail++; $display("FAIL add_result got=%h/%b exp=0105/0", o_res, o_err); end
    n_checks++; if (o_ready_ret != 4) begin n_fail++; $display("FAIL add_accept_interval got=%0d exp=4", o_ready_ret); end
    n_checks++; if (o_en_cnt != 2) begin n_fail++; $display("FAIL add_enable_cycles got=%0d exp=2", o_en_cnt); end
    n_checks++; if (o_first_rsp != 3 || o_rsp_cnt != 1) begin n_fail++; $display("FAIL add_rsp_timing got=%0d/%0d exp=3/1", o_first_rsp, o_rsp_cnt); end
    n_checks++; if (!o_busy_ok) begin n_fail++; $display("FAIL add_busy got=0 exp=1"); end
  endtask

  task automatic test_mul();
    do_txn(8'h04, 8'h78, OP_MUL, 8, 0);
    n_checks++; if (o_res !== 16'h01E0 || o_err !== 1'b0) begin n_fail++; $display("FAIL mul_result got=%h/%b exp=01e0/0", o_res, o_err); end
    n_checks++; if (!o_stable) begin n_fail++; $display("FAIL mul_operands_stable got=0 exp=1"); end
    n_checks++; if (o_first_rsp != 10 || o_en_cnt != 9) begin n_fail++; $display("FAIL mul_timing got=%0d/%0d exp=10/9", o_first_rsp, o_en_cnt); end
  endtask

  task automatic test_illegal();
    do_txn(8'h33, 8'h11, 4'b0101, 1, 0);
    n_checks++; if (o_en_cnt != 0) begin n_fail++; $display("FAIL illegal_enable got=%0d exp=0", o_en_cnt); end
    n_checks++; if (o_res !== 16'h0 || o_err !== 1'b1) begin n_fail++; $display("FAIL illegal_rsp got=%h/%b exp=0000/1", o_res, o_err); end
    n_checks++; if (o_first_rsp != 1 || o_ready_ret != 2) begin n_fail++; $display("FAIL illegal_timing got=%0d/%0d exp=1/2", o_first_rsp, o_ready_ret); end
  endtask

  task automatic test_backpressure();
    do_txn(8'hDA, 8'h2B, OP_SUB, 1, 5);
    n_checks++; if (o_res !== 16'h00AF || o_err !== 1'b0) begin n_fail++; $display("FAIL bp_result got=%h/%b exp=00af/0", o_res, o_err); end
    n_checks++; if (o_rsp_cnt != 6 || !o_held) begin n_fail++; $display("FAIL bp_hold got=%0d/%0b exp=6/1", o_rsp_cnt, o_held); end
    n_checks++; if (o_ready_ret != 9 || o_ready_ret != o_first_rsp + o_rsp_cnt) begin n_fail++; $display("FAIL bp_ready_return got=%0d exp=9", o_ready_ret); end
  endtask

  task automatic test_reset_mid_wait();
    int bad = 0;
    int w = 0;
    while (cmd_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    alu_delay = -1; rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_a = 8'h90; cmd_b = 8'h07; cmd_op = OP_DIV;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b1 || alu_enable !== 1'b1) begin n_fail++; $display("FAIL rstwait_inflight got=%b%b exp=11", busy, alu_enable); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstwait_state got=%b%b%b exp=100", cmd_ready, busy, rsp_valid); end
    n_checks++; if (alu_enable !== 1'b0 || {alu_a, alu_b, alu_op} !== 20'h0 || rsp_result !== 16'h0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL rstwait_outputs got=%b%h%h%b exp=0 0 0 0", alu_enable, {alu_a, alu_b, alu_op}, rsp_result, rsp_err); end
    alu_force_dv = 1'b1;
    repeat (2) @(negedge clk);
    alu_force_dv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) bad++;
      @(negedge clk);
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rstwait_late_dv got=%0d bad cycles exp=0", bad); end
  endtask

  task automatic test_long_wait();
`ifdef ALU_TIMEOUT_EN
    do_txn(8'h12, 8'h34, OP_ADD, -1, 0);
    n_checks++; if (o_res !== 16'h0 || o_err !== 1'b1) begin n_fail++; $display("FAIL timeout_rsp got=%h/%b exp=0000/1", o_res, o_err); end
    n_checks++; if (o_first_rsp != TMO + 2 || o_en_cnt != TMO + 1) begin n_fail++; $display("FAIL timeout_timing got=%0d/%0d exp=%0d/%0d", o_first_rsp, o_en_cnt, TMO + 2, TMO + 1); end
    do_txn(8'h12, 8'h34, OP_ADD, TMO, 0);
    n_checks++; if (o_res !== 16'h0046 || o_err !== 1'b0) begin n_fail++; $display("FAIL timeout_edge_rsp got=%h/%b exp=0046/0", o_res, o_err); end
    n_checks++; if (o_first_rsp != TMO + 2) begin n_fail++; $display("FAIL timeout_edge_timing got=%0d exp=%0d", o_first_rsp, TMO + 2); end
`else
    do_txn(8'h12, 8'h34, OP_ADD, TMO + 8, 0);
    n_checks++; if (o_res !== 16'h0046 || o_err !== 1'b0) begin n_fail++; $display("FAIL longwait_rsp got=%h/%b exp=0046/0", o_res, o_err); end
    n_checks++; if (o_first_rsp != TMO + 10 || o_en_cnt != TMO + 9) begin n_fail++; $display("FAIL longwait_timing got=%0d/%0d exp=%0d/%0d", o_first_rsp, o_en_cnt, TMO + 10, TMO + 9); end
`endif
  endtask

  task automatic test_random();
    for (int t = 0; t < 25; t++) begin
      logic [7:0]  a, b;
      logic [3:0]  op;
      int          d, st, ops;
      bit          legal;
      logic [15:0] exp_res;
      a = 8'($urandom); b = 8'($urandom); op = 4'($urandom_range(0, 7));
      d = $urandom_range(1, 6); st = $urandom_range(0, 3);
      legal   = (op <= 4'd3);
      exp_res = legal ? alu_fn(a, b, op) : 16'h0000;
      ops     = legal ? d + 2 : 1;
      do_txn(a, b, op, d, st);
      n_checks++; if (o_res !== exp_res || o_err !== !legal) begin n_fail++; $display("FAIL rand%0d_rsp got=%h/%b exp=%h/%b", t, o_res, o_err, exp_res, !legal); end
      n_checks++; if (o_first_rsp != ops || o_rsp_cnt != st + 1) begin n_fail++; $display("FAIL rand%0d_rsp_timing got=%0d/%0d exp=%0d/%0d", t, o_first_rsp, o_rsp_cnt, ops, st + 1); end
      n_checks++; if (o_ready_ret != ops + st + 1) begin n_fail++; $display("FAIL rand%0d_ready got=%0d exp=%0d", t, o_ready_ret, ops + st + 1); end
      n_checks++; if (o_en_cnt != (legal ? d + 1 : 0)) begin n_fail++; $display("FAIL rand%0d_enable got=%0d exp=%0d", t, o_en_cnt, legal ? d + 1 : 0); end
      n_checks++; if (!o_held || !o_stable || !o_busy_ok) begin n_fail++; $display("FAIL rand%0d_hold_stable_busy got=%0b%0b%0b exp=111", t, o_held, o_stable, o_busy_ok); end
    end
  endtask

  task automatic test_back_to_back();
    do_txn(8'hFF, 8'hFF, OP_MUL, 1, 0);
    n_checks++; if (o_res !== 16'hFE01 || o_ready_ret != 4) begin n_fail++; $display("FAIL b2b_first got=%h/%0d exp=fe01/4", o_res, o_ready_ret); end
    do_txn(8'hC8, 8'h07, OP_DIV, 1, 0);
    n_checks++; if (o_res !== 16'h001C || o_ready_ret != 4) begin n_fail++; $display("FAIL b2b_second got=%h/%0d exp=001c/4", o_res, o_ready_ret); end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_illegal();
    test_backpressure();
    test_reset_mid_wait();
    test_long_wait();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
